// File: rtl/fetch_stage_pkg.sv
// Shared ez8 definitions: opcode values, opcode field position and fetch FSM encodings.
// No logic of its own; latency not applicable.
// No flow control; consumers import these constants.
package fetch_stage_pkg;

    // Control-flow opcodes carried in the top nibble of an instruction word
    localparam logic [3:0] OP_GOTO = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;

    // Opcode field bit positions within an instruction word
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    // Fetch stage sequencing states
    typedef enum logic [1:0] {
        FLUSH   = 2'd0,
        RUN     = 2'd1,
        RDRAIN1 = 2'd2,
        RDRAIN2 = 2'd3
    } fetch_state_t;

    // Predecoded control-flow class of one instruction
    typedef struct packed {
        logic is_goto;
        logic is_call;
        logic is_ret;
    } predec_t;

    // Classify an opcode nibble; GOTO is also raised for CALL since both redirect the PC
    function automatic predec_t classify_opcode(input logic [3:0] opc);
        predec_t p;
        p.is_goto = (opc == OP_GOTO) || (opc == OP_CALL);
        p.is_call = (opc == OP_CALL);
        p.is_ret  = (opc == OP_RET);
        return p;
    endfunction

endpackage

// File: rtl/fetch_stage_ctrl_predecode.sv
// Control-flow predecoder: instruction word -> is_goto / is_call / is_ret.
// Purely combinational, zero cycles.
// No flow control; output follows the input word every cycle.
module ctrl_predecode
    import fetch_stage_pkg::*;
#(
    parameter int INSTR_WIDTH = 16
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic                   is_goto,
    output logic                   is_call,
    output logic                   is_ret
);

    predec_t    cls;
    logic [3:0] opc;

    // Operand bits carry no control-flow meaning here; fold them so the whole word is consumed
    logic unused_operand_bits;
    assign unused_operand_bits = ^instr;

    assign opc = instr[OPC_MSB:OPC_LSB];

    // Decode the opcode nibble into the three control-flow classes
    always_comb begin
        cls = classify_opcode(opc);
    end

    assign is_goto = cls.is_goto;
    assign is_call = cls.is_call;
    assign is_ret  = cls.is_ret;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch/predecode: drives imem from pc_in, presents instr_out/instr_pc with goto/call/ret strobes.
// Latency: pc_in to instr_out/instr_pc is one cycle (synchronous imem read); strobes are combinational from instr_out.
// Backpressure: pause freezes all state and holds instr_out; optional FETCH_KILL_COUNT_EN builds the kill counter.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pause,
    input  logic [ADDR_WIDTH-1:0]  pc_in,
    input  logic                   kill,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   instr_valid,
    output logic                   goto,
    output logic                   call,
    output logic [ADDR_WIDTH-1:0]  goto_addr,
    output logic                   ret,
    output logic [15:0]            kill_count
);

    fetch_state_t           state_q;
    fetch_state_t           state_d;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic                   fresh_q;
    logic [INSTR_WIDTH-1:0] hold_q;
    logic                   live;
    logic                   is_goto;
    logic                   is_call;
    logic                   is_ret;

    // The memory registers the address on the same edge as pc_q, so its output
    // lines up with pc_q without a second pipeline stage.
    assign imem_addr = pc_in;
    assign instr_pc  = pc_q;

    // While paused the PC controller holds pc_in, so the memory output moves on to
    // the next word; hold_q keeps the word that was on instr_out when pause hit.
    assign instr_out = fresh_q ? imem_rdata : hold_q;

    // PC of the word currently being read out of the memory
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else if (!pause) begin
            pc_q <= pc_in;
        end
    end

    // Select live memory data or the captured copy; reset shows zero until the first fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fresh_q <= 1'b0;
            hold_q  <= '0;
        end else if (pause) begin
            if (fresh_q) begin
                hold_q  <= imem_rdata;
                fresh_q <= 1'b0;
            end
        end else begin
            fresh_q <= 1'b1;
        end
    end

    ctrl_predecode #(
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_predecode (
        .instr   (instr_out),
        .is_goto (is_goto),
        .is_call (is_call),
        .is_ret  (is_ret)
    );

    // An instruction is live only in RUN and when not squashed this cycle
    assign live        = (state_q == RUN) && !kill;
    assign instr_valid = live;
    assign goto        = live && is_goto;
    assign call        = live && is_call;
    assign ret         = live && is_ret;
    assign goto_addr   = instr_out[ADDR_WIDTH-1:0];

    // Sequencing state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FLUSH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a RET starts two drain cycles that discard the pc+1/pc+2 fetches
    always_comb begin
        state_d = state_q;
        if (!pause) begin
            case (state_q)
                FLUSH:   state_d = RUN;
                RUN:     if (ret) state_d = RDRAIN1;
                RDRAIN1: state_d = RDRAIN2;
                RDRAIN2: state_d = RUN;
                default: state_d = FLUSH;
            endcase
        end
    end

`ifdef FETCH_KILL_COUNT_EN
    logic [15:0] kill_cnt_q;
    logic        kill_cnt_inc;

    // Every unpaused cycle that throws an instruction away: a kill in RUN, or a drain slot
    assign kill_cnt_inc = !pause &&
                          (((state_q == RUN) && kill) ||
                           (state_q == RDRAIN1) ||
                           (state_q == RDRAIN2));

    // Saturating squash counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kill_cnt_q <= 16'h0000;
        end else if (kill_cnt_inc && (kill_cnt_q != 16'hFFFF)) begin
            kill_cnt_q <= kill_cnt_q + 16'd1;
        end
    end

    assign kill_count = kill_cnt_q;
`else
    assign kill_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset corner cases and randomized traffic against a reference model.
// Instruction memory is modelled here as a synchronous ROM.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pause = 1'b0;
    logic [11:0] pc_in = '0;
    logic        kill = 1'b0;
    logic [11:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic [15:0] instr_out;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        goto;
    logic        call;
    logic [11:0] goto_addr;
    logic        ret;
    logic [15:0] kill_count;

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] rom [4096];

    fetch_stage #(
        .INSTR_WIDTH (16),
        .ADDR_WIDTH  (12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pause       (pause),
        .pc_in       (pc_in),
        .kill        (kill),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .goto        (goto),
        .call        (call),
        .goto_addr   (goto_addr),
        .ret         (ret),
        .kill_count  (kill_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= rom[imem_addr];

    // ---------------- reference model ----------------
    // Tracks: PC of the word on the output, whether anything has been fetched since
    // reset, the one flush cycle, how many drain slots remain, and the squash count.
    logic [11:0] m_pc;
    bit          m_nofetch;
    bit          m_flush;
    int          m_drain;
    int          m_kc;

    logic        e_v, e_g, e_c, e_r;
    logic [15:0] e_ins;

    task automatic model_reset();
        m_pc = '0; m_nofetch = 1; m_flush = 1; m_drain = 0; m_kc = 0;
    endtask

    task automatic model_eval();
        logic [3:0] op;
        e_ins = m_nofetch ? 16'h0000 : rom[m_pc];
        op    = e_ins[15:12];
        e_v   = !m_flush && (m_drain == 0) && !kill;
        e_g   = e_v && (op == 4'hC || op == 4'hD);
        e_c   = e_v && (op == 4'hD);
        e_r   = e_v && (op == 4'hE);
    endtask

    task automatic model_advance();
        model_eval();
        if (!pause) begin
            if (m_flush) m_flush = 0;
            else if (m_drain > 0) begin
                m_drain--;
                if (m_kc < 65535) m_kc++;
            end else if (kill) begin
                if (m_kc < 65535) m_kc++;
            end else if (e_r) m_drain = 2;
            m_pc = pc_in;
            m_nofetch = 0;
        end
    endtask

    function automatic int kc_exp(input int v);
`ifdef FETCH_KILL_COUNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [15:0] ins, input logic [11:0] ipc,
                           input logic g, input logic c, input logic r, input int kc);
        chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(v));
        chk({tag, ".instr_out"},   32'(instr_out),   32'(ins));
        chk({tag, ".instr_pc"},    32'(instr_pc),    32'(ipc));
        chk({tag, ".goto"},        32'(goto),        32'(g));
        chk({tag, ".call"},        32'(call),        32'(c));
        chk({tag, ".ret"},         32'(ret),         32'(r));
        chk({tag, ".goto_addr"},   32'(goto_addr),   32'(ins[11:0]));
        chk({tag, ".kill_count"},  32'(kill_count),  32'(kc));
        chk({tag, ".imem_addr"},   32'(imem_addr),   32'(pc_in));
    endtask

    // Drive one cycle's inputs and move to the sampling point
    task automatic drive(input logic p, input logic k, input logic [11:0] a);
        pause = p; kill = k; pc_in = a;
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        model_eval();
        chk_all(tag, e_v, e_ins, m_pc, e_g, e_c, e_r, kc_exp(m_kc));
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset(input string tag);
        reset = 1'b1; pause = 1'b0; kill = 1'b0; pc_in = '0;
        #1;
        chk({tag, ".rst_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, ".rst_instr"}, 32'(instr_out),   32'd0);
        chk({tag, ".rst_pc"},    32'(instr_pc),    32'd0);
        chk({tag, ".rst_ret"},   32'(ret),         32'd0);
        chk({tag, ".rst_kc"},    32'(kill_count),  32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        p;
        logic        k;
        logic [11:0] pc;
        logic        v;
        logic [15:0] ins;
        logic [11:0] ipc;
        logic        g;
        logic        c;
        logic        r;
        int          kc;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input logic p, input logic k, input logic [11:0] pc, input logic v,
                                input logic [15:0] ins, input logic [11:0] ipc,
                                input logic g, input logic c, input logic r, input int kc);
        vec_t t;
        t.p = p; t.k = k; t.pc = pc; t.v = v; t.ins = ins; t.ipc = ipc;
        t.g = g; t.c = c; t.r = r; t.kc = kc;
        return t;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] rpc;

        for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);
        rom[0]  = 16'h1234; rom[1]  = 16'h0001; rom[2]  = 16'h0002; rom[3]  = 16'hC0A5;
        rom[4]  = 16'hD100; rom[5]  = 16'h0055; rom[6]  = 16'hE000; rom[7]  = 16'hE000;
        rom[8]  = 16'h0008; rom[9]  = 16'h0009; rom[10] = 16'h000A; rom[11] = 16'hE000;
        rom[12] = 16'h000C; rom[13] = 16'h000D; rom[14] = 16'h000E;

        //                p  k  pc     v  instr     ipc    g  c  r  kc
        tab.push_back(mk(0, 0, 12'd0,  0, 16'h0000, 12'd0,  0, 0, 0, 0)); // flush cycle
        tab.push_back(mk(0, 0, 12'd1,  1, 16'h1234, 12'd0,  0, 0, 0, 0));
        tab.push_back(mk(0, 0, 12'd2,  1, 16'h0001, 12'd1,  0, 0, 0, 0));
        tab.push_back(mk(0, 0, 12'd3,  1, 16'h0002, 12'd2,  0, 0, 0, 0));
        tab.push_back(mk(0, 0, 12'd4,  1, 16'hC0A5, 12'd3,  1, 0, 0, 0)); // GOTO
        tab.push_back(mk(0, 1, 12'd4,  0, 16'hD100, 12'd4,  0, 0, 0, 0)); // killed CALL
        tab.push_back(mk(0, 1, 12'd4,  0, 16'hD100, 12'd4,  0, 0, 0, 1));
        tab.push_back(mk(0, 0, 12'd5,  1, 16'hD100, 12'd4,  1, 1, 0, 2)); // CALL
        tab.push_back(mk(0, 0, 12'd6,  1, 16'h0055, 12'd5,  0, 0, 0, 2));
        tab.push_back(mk(0, 0, 12'd7,  1, 16'hE000, 12'd6,  0, 0, 1, 2)); // RET
        tab.push_back(mk(0, 0, 12'd8,  0, 16'hE000, 12'd7,  0, 0, 0, 2)); // drain 1
        tab.push_back(mk(0, 0, 12'd9,  0, 16'h0008, 12'd8,  0, 0, 0, 3)); // drain 2
        tab.push_back(mk(0, 0, 12'd10, 1, 16'h0009, 12'd9,  0, 0, 0, 4));
        tab.push_back(mk(0, 1, 12'd11, 0, 16'h000A, 12'd10, 0, 0, 0, 4)); // third kill
        for (int i = 0; i < 5; i++)
            tab.push_back(mk(1, 0, 12'd12, 1, 16'hE000, 12'd11, 0, 0, 1, 5)); // paused on RET
        tab.push_back(mk(0, 0, 12'd12, 1, 16'hE000, 12'd11, 0, 0, 1, 5)); // single unpaused ret
        tab.push_back(mk(0, 0, 12'd13, 0, 16'h000C, 12'd12, 0, 0, 0, 5));
        tab.push_back(mk(0, 0, 12'd14, 0, 16'h000D, 12'd13, 0, 0, 0, 6));
        tab.push_back(mk(0, 0, 12'd15, 1, 16'h000E, 12'd14, 0, 0, 0, 7));

        #2;
        do_reset("init");
        for (int i = 0; i < tab.size(); i++) begin
            drive(tab[i].p, tab[i].k, tab[i].pc);
            chk_all($sformatf("vec%0d", i), tab[i].v, tab[i].ins, tab[i].ipc,
                    tab[i].g, tab[i].c, tab[i].r, kc_exp(tab[i].kc));
            finish_cycle();
        end

        // Randomized traffic: mostly sequential PCs with jumps, random pause and kill
        rpc = 12'd15;
        for (int i = 0; i < 1500; i++) begin
            rpc = ($urandom_range(0, 3) == 0) ? 12'($urandom) : rpc + 12'd1;
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, rpc);
            check_model($sformatf("rnd%0d", i));
            finish_cycle();
        end

        // Reset in the middle of a RET drain returns straight to FLUSH
        do_reset("rst2");
        drive(0, 0, 12'd6); check_model("rd0"); finish_cycle();
        drive(0, 0, 12'd7); check_model("rd1"); finish_cycle();
        chk("rd1.ret_seen", 32'(m_drain), 32'd2);
        drive(0, 0, 12'd8); check_model("rd2"); chk("rd2.drain_valid", 32'(instr_valid), 32'd0);
        do_reset("rst_mid_drain");
        drive(0, 0, 12'd1); check_model("rd3"); chk("rd3.flush_valid", 32'(instr_valid), 32'd0); finish_cycle();
        drive(0, 0, 12'd2); check_model("rd4"); finish_cycle();

        // Reset in the middle of a pause
        drive(1, 0, 12'd3); check_model("rp0"); finish_cycle();
        drive(1, 0, 12'd3); check_model("rp1");
        do_reset("rst_mid_pause");
        drive(0, 0, 12'd0); check_model("rp2"); finish_cycle();
        drive(0, 0, 12'd1); check_model("rp3"); finish_cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch/predecode stage sitting between the program counter controller and decode/execute.
- Drives the instruction-memory address from the incoming PC and registers the returned instruction with its PC.
- Predecodes control-flow opcodes into the goto/call/ret strobes the PC controller consumes.
- Squashes instructions on kill and after a return.

Parameters:
- INSTR_WIDTH, 16, instruction word width.
- ADDR_WIDTH, 12, program address width; must match the PC width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pause  in  1  global stall; all state holds while high
- pc_in  in  ADDR_WIDTH  current PC from the PC controller
- kill  in  1  squash the instruction presented this cycle
- imem_addr  out  ADDR_WIDTH  instruction memory address; combinational copy of pc_in
- imem_rdata  in  INSTR_WIDTH  synchronous memory read data, valid one cycle after imem_addr
- instr_out  out  INSTR_WIDTH  registered instruction to decode
- instr_pc  out  ADDR_WIDTH  address of instr_out
- instr_valid  out  1  instr_out is live (not squashed, not flushing)
- goto  out  1  GOTO or CALL predecoded
- call  out  1  CALL predecoded
- goto_addr  out  ADDR_WIDTH  instr_out[ADDR_WIDTH-1:0]
- ret  out  1  RET predecoded
- kill_count  out  16  squashed-instruction count (optional feature)

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state=FLUSH, instr_out=0, instr_pc=0, instr_valid=0, kill_count=0.
  - goto, call and ret are therefore 0.
- Opcode field is instr_out[15:12]:
  - GOTO=4'hC, CALL=4'hD, RET=4'hE.
  - All other opcodes are non-control.
- Fetch path:
  - When !pause, instr_pc <= pc_in registered alongside the address.
  - instr_out is taken from imem_rdata on the following cycle, so instr_out and instr_pc always refer to the same address. Latency from pc_in to instr_out is 1 cycle.
- Strobes:
  - goto, call and ret are combinational from instr_out, gated by instr_valid && !kill.
  - goto = opcode==GOTO || opcode==CALL.
  - call = opcode==CALL.
  - ret = opcode==RET.
- FSM states:
  - FLUSH: instr_valid=0; go to RUN after one unpaused cycle, because the memory output is invalid right after reset.
  - RUN: instr_valid=1 unless kill. If ret is asserted and !pause, go to RDRAIN1.
  - RDRAIN1: instr_valid=0; go to RDRAIN2.
  - RDRAIN2: instr_valid=0; go to RUN.
  - The two drain cycles discard the in-flight pc+1 and pc+2 fetches, because the PC controller does not raise kill on a return.
  - This also guarantees ret is high for exactly one unpaused cycle, so the return stack is popped once.
- pause: freezes state, instr_out, instr_pc and kill_count. Strobes stay driven from the held instruction; the PC controller ignores them while paused.
- kill && RUN: instr_valid=0 and all strobes are 0 that cycle. The FSM does not change state.
- kill during FLUSH/RDRAIN: no extra effect.
- GOTO/CALL need no drain; the PC controller's kill covers the wrong-path fetches.
- goto_addr is the low ADDR_WIDTH bits; no wrap handling is required. PC wrap-around is the PC controller's responsibility.
- Reset mid-drain or mid-pause returns to FLUSH immediately.

Optional Feature:
- Macro: FETCH_KILL_COUNT_EN.
- Defined: kill_count increments by 1 on every unpaused cycle where the FSM is in RUN and kill=1, or the FSM is in RDRAIN1/RDRAIN2. It saturates at 16'hFFFF and resets to 0.
- Undefined: kill_count is tied to 16'h0000 and no counter logic is built.

Decomposition:
- Shared header (ez8_defs): opcode localparams OP_GOTO/OP_CALL/OP_RET, opcode field bit positions, FSM state encodings (FLUSH=2'd0, RUN=2'd1, RDRAIN1=2'd2, RDRAIN2=2'd3).
- One sub-module, ctrl_predecode: purely combinational; maps instruction to is_goto/is_call/is_ret. It is reused later by the decode stage.

Test Plan:
- Reset, then pc_in 0,1,2 with ROM[0]=16'h1234: instr_valid=0 in the first cycle after reset; then instr_out=16'h1234, instr_pc=0, instr_valid=1.
- ROM[3]=16'hC0A5 (GOTO 0x0A5) reaches instr_out: goto=1, call=0, goto_addr=12'h0A5 for one cycle. Kill=1 on the next 2 cycles gives instr_valid=0 and no strobes.
- ROM[4]=16'hD100 (CALL 0x100): goto=1, call=1, goto_addr=12'h100.
- ROM[6]=16'hE000 (RET): ret=1 for exactly one cycle. The next two instructions have instr_valid=0 and ret=0, even if ROM[7]=16'hE000.
- Pause held 5 cycles while a RET is at instr_out: state and instr_out frozen, no transition to RDRAIN1. After release, exactly one unpaused ret cycle occurs.
- With FETCH_KILL_COUNT_EN: 3 kill cycles plus one RET drain give kill_count=5. Without the macro, kill_count stays 0.
